multicycle_control_unit: RTL and testbench

- Multicycle successor to the single-cycle main/ALU decoder.
- A Moore-style FSM sequences each MIPS instruction over 3–5+ cycles through a shared ALU and a shared instruction/data memory.
- Adds memory wait-state handshaking, illegal-instruction detection and an instruction-retired pulse.
- Sits between the instruction register (which supplies opcode/funct) and the multicycle datapath muxes, register file and memory.

---
 rtl/multicycle_control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute through a
// shared ALU and memory, with wait states, illegal-op and retire pulses.
module multicycle_control_unit #(
  parameter bit ENABLE_MUL    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wrt,
  output logic       ir_write,
  output logic       reg_des,
  output logic       mem_to_reg,
  output logic       reg_wrt,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] ALU_control,
  output logic       illegal_op,
  output logic       instr_retired,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  state_t     cur;
  state_t     nxt;
  state_t     dec_tgt;
  logic       ready;
  logic       r_legal;
  logic       op_legal;
  logic [2:0] r_alu;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = cur;

  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case (funct)
      F_ADD:   r_alu = ALU_ADD;
      F_SUB:   r_alu = ALU_SUB;
      F_SLT:   r_alu = ALU_SLT;
      F_MUL: begin
        r_alu   = ALU_MUL;
        r_legal = ENABLE_MUL;
      end
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    op_legal = 1'b1;
    dec_tgt  = S_FETCH;
    case (opcode)
      OP_LW,
      OP_SW:    dec_tgt = S_MEMADR;
      OP_RTYPE: begin
        dec_tgt  = S_EXEC;
        op_legal = r_legal;
      end
      OP_ADDI:  dec_tgt = S_ADDIEX;
      OP_BEQ:   dec_tgt = S_BRANCH;
      OP_J:     dec_tgt = S_JUMP;
      default:  op_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = op_legal ? dec_tgt : S_FETCH;
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  // Outputs are forced to their idle values for as long as rst is high.
  always_comb begin
    pc_write      = 1'b0;
    iord          = 1'b0;
    mem_rd        = 1'b0;
    mem_wrt       = 1'b0;
    ir_write      = 1'b0;
    reg_des       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_wrt       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    ALU_control   = ALU_ADD;
    illegal_op    = 1'b0;
    instr_retired = 1'b0;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = ready;
          ir_write  = ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !op_legal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        S_MEMWB: begin
          reg_wrt       = 1'b1;
          mem_to_reg    = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWR: begin
          mem_wrt       = 1'b1;
          iord          = 1'b1;
          instr_retired = ready;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          ALU_control = r_alu;
        end
        S_ALUWB: begin
          reg_wrt       = 1'b1;
          reg_des       = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          ALU_control   = ALU_SUB;
          pc_src        = 2'b01;
          pc_write      = zero;
          instr_retired = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          reg_wrt       = 1'b1;
          instr_retired = 1'b1;
        end
        S_JUMP: begin
          pc_src        = 2'b10;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default build plus a
// build without mul, driven in lockstep from one stimulus sequence.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write, iord, mem_rd, mem_wrt, ir_write, reg_des;
  logic       mem_to_reg, reg_wrt, alu_src_a, illegal_op, instr_retired;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] ALU_control;
  logic [3:0] state;

  logic       pc_write2, iord2, mem_rd2, mem_wrt2, ir_write2, reg_des2;
  logic       mem_to_reg2, reg_wrt2, alu_src_a2, illegal_op2, instr_retired2;
  logic [1:0] alu_src_b2, pc_src2;
  logic [2:0] ALU_control2;
  logic [3:0] state2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
    .mem_rd(mem_rd), .mem_wrt(mem_wrt), .ir_write(ir_write),
    .reg_des(reg_des), .mem_to_reg(mem_to_reg), .reg_wrt(reg_wrt),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .ALU_control(ALU_control), .illegal_op(illegal_op),
    .instr_retired(instr_retired), .state(state)
  );

  multicycle_control_unit #(.ENABLE_MUL(1'b0), .MEM_HANDSHAKE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write2), .iord(iord2),
    .mem_rd(mem_rd2), .mem_wrt(mem_wrt2), .ir_write(ir_write2),
    .reg_des(reg_des2), .mem_to_reg(mem_to_reg2), .reg_wrt(reg_wrt2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_src(pc_src2),
    .ALU_control(ALU_control2), .illegal_op(illegal_op2),
    .instr_retired(instr_retired2), .state(state2)
  );

  wire [17:0] v1 = {pc_write, iord, mem_rd, mem_wrt, ir_write, reg_des,
                    mem_to_reg, reg_wrt, alu_src_a, alu_src_b, pc_src,
                    ALU_control, illegal_op, instr_retired};
  wire [17:0] v2 = {pc_write2, iord2, mem_rd2, mem_wrt2, ir_write2, reg_des2,
                    mem_to_reg2, reg_wrt2, alu_src_a2, alu_src_b2, pc_src2,
                    ALU_control2, illegal_op2, instr_retired2};

  // Packs expected outputs in the same order as v1/v2.
  function automatic logic [17:0] pk(
    input logic pcw, io, mrd, mwr, irw, rd, m2r, rw, sa,
    input logic [1:0] sb, ps, input logic [2:0] alu,
    input logic ill, ret);
    return {pcw, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ps, alu, ill, ret};
  endfunction

  logic [17:0] V_RST, V_FR, V_FW, V_DEC, V_DECI, V_ALUWB;
  logic [17:0] V_MADR, V_MRD, V_MWB, V_AIEX, V_AIWB, V_JMP;

  function automatic logic [17:0] v_exec(input logic [2:0] a);
    return pk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, a, 0,0);
  endfunction
  function automatic logic [17:0] v_br(input logic z);
    return pk(z,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b100, 0,1);
  endfunction
  function automatic logic [17:0] v_mwr(input logic r);
    return pk(0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0,r);
  endfunction

  task automatic chk(input string tag, input logic [3:0] es,
                     input logic [17:0] ev);
    n_chk++;
    assert (state === es) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
    end
    n_chk++;
    assert (v1 === ev) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, v1, ev);
    end
  endtask

  task automatic chk2(input string tag, input logic [3:0] es,
                      input logic [17:0] ev);
    n_chk++;
    assert (state2 === es) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state2, es);
    end
    n_chk++;
    assert (v2 === ev) else begin
      n_fail++;
      $error("FAIL %s outputs: observed %b expected %b", tag, v2, ev);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [5:0] fl [3];
  logic [2:0] al [3];

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    V_RST   = pk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0,0);
    V_FR    = pk(1,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
    V_FW    = pk(0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
    V_DEC   = pk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0,0);
    V_DECI  = pk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 1,0);
    V_ALUWB = pk(0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'b010, 0,1);
    V_MADR  = pk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0);
    V_MRD   = pk(0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, 0,0);
    V_MWB   = pk(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b010, 0,1);
    V_AIEX  = pk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0);
    V_AIWB  = pk(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b010, 0,1);
    V_JMP   = pk(1,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010, 0,1);
    fl[0] = 6'b100010; al[0] = 3'b100;
    fl[1] = 6'b101010; al[1] = 3'b110;
    fl[2] = 6'b011100; al[2] = 3'b101;

    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    opcode = 6'b000000; funct = 6'b100000;
    #3;
    chk("rst_hold", 4'd0, V_RST);
    chk2("rst_hold2", 4'd0, V_RST);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // R-type add, then sub/slt/mul
    chk("add_fetch", 4'd0, V_FR);
    tick; chk("add_dec", 4'd1, V_DEC);
    tick; chk("add_exec", 4'd6, v_exec(3'b010));
    tick; chk("add_wb", 4'd7, V_ALUWB);
    tick; chk("add_done", 4'd0, V_FR);
    chk2("add_done2", 4'd0, V_FR);
    for (int i = 0; i < 3; i++) begin
      funct = fl[i];
      tick; chk("r_dec", 4'd1, V_DEC);
      if (i == 2) chk2("mul_off_dec", 4'd1, V_DECI);
      tick; chk("r_exec", 4'd6, v_exec(al[i]));
      if (i == 2) chk2("mul_off_next", 4'd0, V_FR);
      tick; chk("r_wb", 4'd7, V_ALUWB);
      if (i == 2) chk2("mul_off_dec_b", 4'd1, V_DECI);
      tick; chk("r_done", 4'd0, V_FR);
    end
    do_reset;

    // lw with two wait cycles in MEMRD
    opcode = 6'b100011;
    chk("lw_fetch", 4'd0, V_FR);
    tick; chk("lw_dec", 4'd1, V_DEC);
    tick; mem_ready = 1'b0; #1;
    chk("lw_madr", 4'd2, V_MADR);
    tick; chk("lw_mrd1", 4'd3, V_MRD);
    tick; chk("lw_mrd2", 4'd3, V_MRD);
    tick; mem_ready = 1'b1; #1;
    chk("lw_mrd3", 4'd3, V_MRD);
    tick; chk("lw_mwb", 4'd4, V_MWB);
    tick; chk("lw_done", 4'd0, V_FR);

    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1;
    tick; chk("beq1_dec", 4'd1, V_DEC);
    tick; chk("beq1_br", 4'd8, v_br(1'b1));
    tick; chk("beq1_done", 4'd0, V_FR);
    zero = 1'b0;
    tick; chk("beq0_dec", 4'd1, V_DEC);
    tick; chk("beq0_br", 4'd8, v_br(1'b0));
    tick; chk("beq0_done", 4'd0, V_FR);

    // addi and j
    opcode = 6'b001000;
    tick; chk("addi_dec", 4'd1, V_DEC);
    tick; chk("addi_ex", 4'd9, V_AIEX);
    tick; chk("addi_wb", 4'd10, V_AIWB);
    opcode = 6'b000010;
    tick; chk("j_fetch", 4'd0, V_FR);
    tick; chk("j_dec", 4'd1, V_DEC);
    tick; chk("j_jump", 4'd11, V_JMP);
    tick; chk("j_done", 4'd0, V_FR);

    // illegal opcode on both builds
    do_reset;
    opcode = 6'b111111;
    tick; chk("ill_dec", 4'd1, V_DECI);
    chk2("ill_dec2", 4'd1, V_DECI);
    tick; chk("ill_next", 4'd0, V_FR);
    chk2("ill_next2", 4'd0, V_FR);

    // sw completing without wait
    opcode = 6'b101011;
    tick; chk("sw_dec", 4'd1, V_DEC);
    tick; chk("sw_madr", 4'd2, V_MADR);
    tick; chk("sw_mwr", 4'd5, v_mwr(1'b1));
    tick; chk("sw_done", 4'd0, V_FR);

    // sw aborted by reset in its second MEMWR cycle
    tick; chk("swr_dec", 4'd1, V_DEC);
    tick; chk("swr_madr", 4'd2, V_MADR);
    tick; mem_ready = 1'b0; #1;
    chk("swr_mwr1", 4'd5, v_mwr(1'b0));
    tick; chk("swr_mwr2", 4'd5, v_mwr(1'b0));
    #1; rst = 1'b1; #1;
    chk("swr_abort", 4'd0, V_RST);
    @(negedge clk);
    rst = 1'b0; opcode = 6'b000010;
    #1;

    // FETCH stalls three cycles, then loads on mem_ready
    chk("stall1", 4'd0, V_FW);
    tick; chk("stall2", 4'd0, V_FW);
    tick; chk("stall3", 4'd0, V_FW);
    tick; mem_ready = 1'b1; #1;
    chk("stall_go", 4'd0, V_FR);
    tick; chk("stall_dec", 4'd1, V_DEC);
    tick; chk("stall_jump", 4'd11, V_JMP);
    tick; chk("stall_done", 4'd0, V_FR);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
